// File: rtl/comp_seq_wide_pkg.sv
// ============================================================================
// Module  : comp_seq_wide_pkg
// Brief   : Shared state encoding, result one-hot constants and size limits
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package comp_seq_wide_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_LT = 3'b010;
    localparam logic [2:0] RES_EQ = 3'b001;

    localparam int NIBBLES_MIN = 1;
    localparam int NIBBLES_MAX = 16;

endpackage

`default_nettype wire

// File: rtl/comp_seq_wide_comp4.sv
// ============================================================================
// Module  : comp_seq_wide_comp4
// Brief   : 4-bit unsigned magnitude comparator (one-hot gt/lt/eq)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module comp_seq_wide_comp4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic       o_gt,
    output logic       o_lt,
    output logic       o_eq
);

    assign o_gt = (i_a >  i_b);
    assign o_lt = (i_a <  i_b);
    assign o_eq = (i_a == i_b);

endmodule

`default_nettype wire

// File: rtl/comp_seq_wide.sv
// ============================================================================
// Module  : comp_seq_wide
// Brief   : Sequential NIBBLES*4-bit magnitude comparator, MSB nibble first.
//           Define COMP_SIGNED_EN for two's-complement operands.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module comp_seq_wide
    import comp_seq_wide_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] A_nib,
    input  logic [3:0] B_nib,
    output logic       busy,
    output logic       done,
    output logic       A_gt_B,
    output logic       A_lt_B,
    output logic       A_eq_B
);

    localparam int              CNT_W  = $clog2(NIBBLES + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(NIBBLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_decided;
    logic             r_dir_gt;
    logic [2:0]       r_res;

    logic             w_accept;
    logic             w_last;
    logic             w_restart;
    logic [3:0]       w_a;
    logic [3:0]       w_b;
    logic             w_gt;
    logic             w_lt;
    logic             w_eq;
    logic [2:0]       w_final;

    assign w_accept  = in_valid && (r_state == LOAD);
    assign w_last    = w_accept && (r_cnt == c_last);
    assign w_restart = start && ((r_state == IDLE) || (r_state == DONE));

`ifdef COMP_SIGNED_EN
    // Flipping the sign bit of the leading nibble maps two's complement onto
    // offset binary, so the unsigned nibble compare still orders correctly.
    logic w_first;
    assign w_first = (r_cnt == '0);
    assign w_a     = {A_nib[3] ^ w_first, A_nib[2:0]};
    assign w_b     = {B_nib[3] ^ w_first, B_nib[2:0]};
`else
    assign w_a     = A_nib;
    assign w_b     = B_nib;
`endif

    comp_seq_wide_comp4 u_comp4 (
        .i_a  (w_a),
        .i_b  (w_b),
        .o_gt (w_gt),
        .o_lt (w_lt),
        .o_eq (w_eq)
    );

    // The final nibble can still be the deciding one, so fold it in here.
    always_comb begin
        w_final = RES_EQ;
        if (r_decided) begin
            w_final = r_dir_gt ? RES_GT : RES_LT;
        end else if (w_gt) begin
            w_final = RES_GT;
        end else if (w_lt) begin
            w_final = RES_LT;
        end else if (w_eq) begin
            w_final = RES_EQ;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_next = LOAD;
            LOAD:    if (w_last) w_next = DONE;
            DONE:    w_next = start ? LOAD : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_dir_gt  <= 1'b0;
            r_res     <= 3'b000;
        end else begin
            r_state <= w_next;
            if (w_restart) begin
                r_cnt     <= '0;
                r_decided <= 1'b0;
            end else if (w_accept) begin
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                if (!r_decided && (w_gt || w_lt)) begin
                    r_decided <= 1'b1;
                    r_dir_gt  <= w_gt;
                end
            end
            if (w_last) begin
                r_res <= w_final;
            end
        end
    end

    assign in_ready = (r_state == LOAD);
    assign busy     = (r_state == LOAD);
    assign done     = (r_state == DONE);
    assign A_gt_B   = r_res[2];
    assign A_lt_B   = r_res[1];
    assign A_eq_B   = r_res[0];

endmodule

`default_nettype wire
